// File: rtl/iq_mixer_mc.sv
// Time-multiplexed NCH-channel IQ mixer: one ADC sample against NCH NCOs through one shared multiplier pair.
// Optional: define IQ_MIXER_DITHER_EN to add 16b LFSR phase dither below the LUT address.
module iq_mixer_mc #(
    parameter int IN_WIDTH  = 14,
    parameter int OUT_WIDTH = 18,
    parameter int NCH       = 4,
    parameter int PHASE_W   = 48,
    parameter int LUT_AW    = 10,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        busy,
    output logic                        overrun,
    input  logic                        freq_wr,
    input  logic [CH_W-1:0]             freq_ch,
    input  logic [PHASE_W-1:0]          freq_data,
    input  logic                        phase_clr,
    output logic                        out_valid,
    output logic [CH_W-1:0]             out_ch,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q
);

    localparam int LUT_N = 2 ** LUT_AW;
    localparam int QTR   = 2 ** (LUT_AW - 2);
    localparam int MUL_W = 36;
    localparam int SH    = IN_WIDTH + 17 - OUT_WIDTH;
    localparam int RSH   = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [MUL_W:0] RND     = (SH > 0) ? ((MUL_W + 1)'(1) << RSH) : '0;
    localparam logic signed [MUL_W:0] SAT_MAX = (MUL_W + 1)'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
    localparam logic signed [MUL_W:0] SAT_MIN = -SAT_MAX;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic signed [17:0] lut_entry(input int j);
        real v;
        int  r;
        v = 131071.0 * $sin(2.0 * 3.14159265358979323846 * real'(j) / real'(LUT_N));
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return 18'(r);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat_rnd(input logic signed [MUL_W-1:0] p);
        logic signed [MUL_W:0]         s;
        logic signed [OUT_WIDTH-1:0]   r;
        s = ((MUL_W + 1)'(p) + RND) >>> SH;
        if (s > SAT_MAX)      r = SAT_MAX[OUT_WIDTH-1:0];
        else if (s < SAT_MIN) r = SAT_MIN[OUT_WIDTH-1:0];
        else                  r = s[OUT_WIDTH-1:0];
        return r;
    endfunction

    logic signed [17:0] lut_w [LUT_N];
    for (genvar j = 0; j < LUT_N; j++) begin : g_lut
        localparam logic signed [17:0] LV = lut_entry(j);
        assign lut_w[j] = LV;
    end

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic signed [IN_WIDTH-1:0]  sample_q;
    logic                        overrun_q;
    logic [PHASE_W-1:0]          inc_pend_q [NCH];
    logic [PHASE_W-1:0]          inc_act_q  [NCH];
    logic [PHASE_W-1:0]          acc_q      [NCH];
    logic                        slot, last, accept, drop, ch_ok;
    logic [LUT_AW-1:0]           addr_w;

    assign slot    = (state_q == RUN);
    assign last    = (ch_q == CH_W'(NCH - 1));
    assign busy    = slot;
    assign overrun = overrun_q;

    if (NCH == (1 << CH_W)) begin : g_ch_full
        assign ch_ok = 1'b1;
    end else begin : g_ch_part
        assign ch_ok = (int'(freq_ch) < NCH);
    end

    // A sample is taken when idle or in the last channel slot, so frames can run back to back.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        accept  = 1'b0;
        drop    = 1'b0;
        if (phase_clr) begin
            state_d = IDLE;
            ch_d    = '0;
        end else begin
            if (in_valid) begin
                if (!slot || last) accept = 1'b1;
                else               drop   = 1'b1;
            end
            if (accept) begin
                state_d = RUN;
                ch_d    = '0;
            end else if (slot) begin
                if (last) begin
                    state_d = IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (accept) sample_q <= in_data;
            if (phase_clr) overrun_q <= 1'b0;
            else if (drop) overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                inc_pend_q[k] <= '0;
                inc_act_q[k]  <= '0;
                acc_q[k]      <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (accept) inc_act_q[k] <= inc_pend_q[k];
                if (freq_wr && ch_ok && (freq_ch == CH_W'(k))) inc_pend_q[k] <= freq_data;
                if (phase_clr)                       acc_q[k] <= '0;
                else if (slot && (ch_q == CH_W'(k))) acc_q[k] <= acc_q[k] + inc_act_q[k];
            end
        end
    end

`ifdef IQ_MIXER_DITHER_EN
    logic [15:0] lfsr_q;
    logic        dith_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr_q <= 16'hACE1;
        else if (slot) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // The dither only reaches the address as a carry out of the 16 bits it overlaps.
    assign dith_c = acc_q[ch_q][PHASE_W-LUT_AW-1 -: 16] > ~lfsr_q;
    assign addr_w = acc_q[ch_q][PHASE_W-1 -: LUT_AW] + LUT_AW'(dith_c);
`else
    assign addr_w = acc_q[ch_q][PHASE_W-1 -: LUT_AW];
`endif

    logic                        v1_q, v2_q, out_valid_q;
    logic [CH_W-1:0]             ch1_q, ch2_q, out_ch_q;
    logic signed [IN_WIDTH-1:0]  x1_q;
    logic signed [17:0]          sin1_q, cos1_q;
    logic signed [MUL_W-1:0]     pi2_q, pq2_q;
    logic signed [OUT_WIDTH-1:0] out_i_q, out_q_q;
    logic signed [MUL_W-1:0]     xe_w, ce_w, se_w;

    assign xe_w = MUL_W'(x1_q);
    assign ce_w = MUL_W'(cos1_q);
    assign se_w = MUL_W'(sin1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            ch1_q       <= '0;
            x1_q        <= '0;
            sin1_q      <= '0;
            cos1_q      <= '0;
            v2_q        <= 1'b0;
            ch2_q       <= '0;
            pi2_q       <= '0;
            pq2_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            v1_q   <= slot && !phase_clr;
            ch1_q  <= ch_q;
            x1_q   <= sample_q;
            sin1_q <= lut_w[addr_w];
            cos1_q <= lut_w[addr_w + LUT_AW'(QTR)];

            v2_q  <= v1_q && !phase_clr;
            ch2_q <= ch1_q;
            pi2_q <= xe_w * ce_w;
            pq2_q <= xe_w * se_w;

            out_valid_q <= v2_q && !phase_clr;
            if (v2_q) begin
                out_ch_q <= ch2_q;
                out_i_q  <= sat_rnd(pi2_q);
                out_q_q  <= sat_rnd(pq2_q);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;

endmodule

// File: tb/tb_iq_mixer_mc.sv
// Randomized self-checking bench for iq_mixer_mc against a frame-level reference model.
module tb_iq_mixer_mc;

    localparam int IN_WIDTH  = 14;
    localparam int OUT_WIDTH = 18;
    localparam int NCH       = 4;
    localparam int PHASE_W   = 48;
    localparam int LUT_AW    = 10;
    localparam int CH_W      = 2;
    localparam int LUT_N     = 1 << LUT_AW;
    localparam int SH        = IN_WIDTH + 17 - OUT_WIDTH;
    localparam longint SATV  = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic                        in_valid = 1'b0;
    logic signed [IN_WIDTH-1:0]  in_data = '0;
    logic                        freq_wr = 1'b0;
    logic [CH_W-1:0]             freq_ch = '0;
    logic [PHASE_W-1:0]          freq_data = '0;
    logic                        phase_clr = 1'b0;
    logic                        busy, overrun, out_valid;
    logic [CH_W-1:0]             out_ch;
    logic signed [OUT_WIDTH-1:0] out_i, out_q;

    iq_mixer_mc #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .NCH      (NCH),
        .PHASE_W  (PHASE_W),
        .LUT_AW   (LUT_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .overrun  (overrun),
        .freq_wr  (freq_wr),
        .freq_ch  (freq_ch),
        .freq_data(freq_data),
        .phase_clr(phase_clr),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_i    (out_i),
        .out_q    (out_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ch;
        int i;
        int q;
    } exp_t;

    int                 lut_ref [LUT_N];
    logic [PHASE_W-1:0] m_acc  [NCH];
    logic [PHASE_W-1:0] m_pend [NCH];
    logic [PHASE_W-1:0] m_act  [NCH];
    bit                 m_ovr;
    int                 free_at;
    int                 cyc;
    exp_t               expq [$];
    int                 n_checks;
    int                 n_errors;
    bit                 log_en;
    int                 log_i [$];
    int                 log_q [$];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clamp(input longint v);
        if (v > SATV)  return int'(SATV);
        if (v < -SATV) return int'(-SATV);
        return int'(v);
    endfunction

    function automatic void ref_iq(input logic [PHASE_W-1:0] ph, input int x, output int ei, output int eq);
        int     a;
        longint c, s;
        a  = int'(ph[PHASE_W-1 -: LUT_AW]);
        s  = longint'(lut_ref[a]);
        c  = longint'(lut_ref[(a + LUT_N / 4) % LUT_N]);
        ei = clamp((longint'(x) * c + (64'sd1 <<< (SH - 1))) >>> SH);
        eq = clamp((longint'(x) * s + (64'sd1 <<< (SH - 1))) >>> SH);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_acc[k]  = '0;
            m_pend[k] = '0;
            m_act[k]  = '0;
        end
        m_ovr   = 1'b0;
        free_at = 0;
        expq.delete();
    endtask

    // Whole frame is resolved at the accepting edge; outputs are scheduled at T+3+k.
    task automatic model_edge();
        exp_t e;
        if (phase_clr) begin
            for (int k = 0; k < NCH; k++) m_acc[k] = '0;
            expq.delete();
            m_ovr   = 1'b0;
            free_at = cyc;
        end else if (in_valid) begin
            if (cyc >= free_at) begin
                for (int k = 0; k < NCH; k++) m_act[k] = m_pend[k];
                for (int k = 0; k < NCH; k++) begin
                    e.due = cyc + 3 + k;
                    e.ch  = k;
                    ref_iq(m_acc[k], int'(in_data), e.i, e.q);
                    expq.push_back(e);
                    m_acc[k] = m_acc[k] + m_act[k];
                end
                free_at = cyc + NCH;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (freq_wr && (int'(freq_ch) < NCH)) m_pend[freq_ch] = freq_data;
    endtask

    task automatic compare();
        exp_t e;
        check_val("busy", longint'(busy), longint'(cyc < free_at));
        check_val("overrun", longint'(overrun), longint'(m_ovr));
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            check_val("out_valid", longint'(out_valid), 1);
            check_val("out_ch", longint'(out_ch), longint'(e.ch));
            check_val("out_i", longint'(out_i), longint'(e.i));
            check_val("out_q", longint'(out_q), longint'(e.q));
            if (log_en && e.ch == 0) begin
                log_i.push_back(int'(out_i));
                log_q.push_back(int'(out_q));
            end
        end else begin
            check_val("out_valid", longint'(out_valid), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
    endtask

    task automatic step(input bit iv, input int x, input bit fw, input int fch,
                        input logic [PHASE_W-1:0] fd, input bit clr);
        in_valid  = iv;
        in_data   = IN_WIDTH'(x);
        freq_wr   = fw;
        freq_ch   = CH_W'(fch);
        freq_data = fd;
        phase_clr = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_overrun", longint'(overrun), 0);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_out_ch", longint'(out_ch), 0);
        check_val("rst_out_i", longint'(out_i), 0);
        check_val("rst_out_q", longint'(out_q), 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic check_ch0_log(input string tag, input int n, input int ei [4], input int eq [4]);
        check_val({tag, "_count"}, longint'(log_i.size()), longint'(n));
        if (log_i.size() >= n) begin
            for (int f = 0; f < n; f++) begin
                check_val({tag, "_I"}, longint'(log_i[f]), longint'(ei[f]));
                check_val({tag, "_Q"}, longint'(log_q[f]), longint'(eq[f]));
            end
        end
        log_i.delete();
        log_q.delete();
    endtask

    initial begin
        int                 gi [4];
        int                 gq [4];
        logic [PHASE_W-1:0] q46;
        real                v;

        gi = '{131055, 0, -131055, 0};
        gq = '{0, 131055, 0, -131055};
        q46 = PHASE_W'(1) << 46;
        for (int j = 0; j < LUT_N; j++) begin
            v = 131071.0 * $sin(2.0 * 3.14159265358979323846 * real'(j) / real'(LUT_N));
            lut_ref[j] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        end
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        log_en   = 1'b0;
        model_reset();

        #2;
        do_reset();
        idle(1);

        // Quarter-turn increment on ch0, full-scale positive sample, four back-to-back frames.
        step(1'b0, 0, 1'b1, 0, q46, 1'b0);
        log_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 8191, 1'b0, 0, '0, 1'b0);
            idle(NCH - 1);
        end
        idle(6);
        log_en = 1'b0;
        check_ch0_log("quarter", 4, gi, gq);

        // Zero increments, most negative sample.
        step(1'b0, 0, 1'b1, 0, '0, 1'b1);
        step(1'b1, -8192, 1'b0, 0, '0, 1'b0);
        idle(8);

        // in_valid every clock for 8 clocks, then clear the sticky overrun.
        for (int i = 0; i < 8; i++) step(1'b1, $urandom_range(0, 16383) - 8192, 1'b0, 0, '0, 1'b0);
        idle(8);
        step(1'b0, 0, 1'b0, 0, '0, 1'b1);
        idle(2);

        // Increment written mid-frame applies from the following frame.
        step(1'b1, 8191, 1'b0, 0, '0, 1'b0);
        step(1'b0, 0, 1'b1, 2, q46, 1'b0);
        idle(2);
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 5000, 1'b0, 0, '0, 1'b0);
            idle(NCH - 1);
        end
        idle(6);

        // Clear four clocks into a frame, then a clear colliding with in_valid.
        step(1'b1, 7000, 1'b0, 0, '0, 1'b0);
        idle(3);
        step(1'b0, 0, 1'b0, 0, '0, 1'b1);
        idle(4);
        step(1'b1, -3000, 1'b0, 0, '0, 1'b0);
        idle(8);
        step(1'b1, 1234, 1'b0, 0, '0, 1'b1);
        idle(4);

        // Asynchronous reset two clocks into a frame, then repeat the first quarter-turn frame.
        step(1'b1, 8191, 1'b0, 0, '0, 1'b0);
        idle(2);
        do_reset();
        step(1'b0, 0, 1'b1, 0, q46, 1'b0);
        log_en = 1'b1;
        step(1'b1, 8191, 1'b0, 0, '0, 1'b0);
        idle(8);
        log_en = 1'b0;
        check_ch0_log("after_reset", 1, gi, gq);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) == 0,
                 $urandom_range(0, 16383) - 8192,
                 ($urandom % 8) == 0,
                 $urandom_range(0, NCH - 1),
                 {$urandom, $urandom},
                 ($urandom % 50) == 0);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
